// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared grant type, geometry defaults and helpers for the frame-buffer arbiter
package fb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_WRITE = 2'd2
    } gnt_t;

    localparam int FB_W_DEF   = 320;
    localparam int FB_H_DEF   = 240;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 12;

    localparam int DISP_W = 640;
    localparam int DISP_H = 480;
    localparam int POS_W  = 12;

    function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// rtl/fb_addr_gen.sv - combinational 640x480 scan position to 2x-downscaled buffer address
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int FB_W   = FB_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [POS_W-1:0]  xpose,
    input  logic [POS_W-1:0]  ypose,
    output logic [ADDR_W-1:0] fb_addr
);

    logic [ADDR_W:0] row;
    logic [ADDR_W:0] col;
    logic [ADDR_W:0] row_base;
    logic [ADDR_W:0] sum;
    logic            unused_bits;

    // Position LSBs vanish in the 2x downscale; the carry bit is dropped by truncation.
    assign unused_bits = xpose[0] ^ ypose[0] ^ sum[ADDR_W];

    assign row = (ADDR_W+1)'(ypose[POS_W-1:1]);
    assign col = (ADDR_W+1)'(xpose[POS_W-1:1]);

    // 320 = 256 + 64, so the default width needs only two shifts and an add.
    generate
        if (FB_W == 320) begin : g_w320
            assign row_base = (row << 8) + (row << 6);
        end else begin : g_wgen
            assign row_base = row * (ADDR_W+1)'(FB_W);
        end
    endgenerate

    assign sum     = row_base + col;
    assign fb_addr = sum[ADDR_W-1:0];

endmodule

// File: rtl/fb_scan_arbiter.sv
// rtl/fb_scan_arbiter.sv - frame-buffer RAM arbiter: display fetch priority, client writes, pixel register
module fb_scan_arbiter
    import fb_pkg::*;
#(
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              clk_div,
    input  logic              disp_active,
    input  logic [POS_W-1:0]  xpose,
    input  logic [POS_W-1:0]  ypose,
    input  logic              wr_blank_only,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel,
    output logic              pixel_valid,
    output logic [7:0]        wr_stall_max
);

    gnt_t              gnt;
    gnt_t              gnt_next;
    logic              fetch_slot;
    logic              write_slot;
    logic              wr_ack_q;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        stall_cnt;
    logic [7:0]        stall_max;
    logic              unused_geometry_ok;

    // Geometry sanity flag: the buffer must fit in the address space.
    assign unused_geometry_ok = ((FB_W * FB_H - 1) < (1 << ADDR_W));

    fb_addr_gen #(
        .FB_W   (FB_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .xpose   (xpose),
        .ypose   (ypose),
        .fb_addr (fb_addr)
    );

    // Grant decision: display fetch is absolute; a write needs a free, non-back-to-back cycle.
    always_comb begin
        gnt_next   = GNT_NONE;
        fetch_slot = clk_div && disp_active;
        write_slot = !fetch_slot && wr_req && !wr_ack_q && (!wr_blank_only || !disp_active);
        if (rst) begin
            gnt_next = GNT_NONE;
        end else if (fetch_slot) begin
            gnt_next = GNT_FETCH;
        end else if (write_slot) begin
            gnt_next = GNT_WRITE;
        end
    end

    assign wr_ack       = (gnt_next == GNT_WRITE);
    assign wr_stall_max = stall_max;

    // Grant register and registered RAM command; address/data hold when idle.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            gnt       <= GNT_NONE;
            wr_ack_q  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt      <= gnt_next;
            wr_ack_q <= wr_ack;
            mem_en   <= (gnt_next != GNT_NONE);
            mem_we   <= (gnt_next == GNT_WRITE);
            case (gnt_next)
                GNT_FETCH: begin
                    mem_addr <= fb_addr;
                end
                GNT_WRITE: begin
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Pixel register: capture the read issued last cycle; blank on a tick outside the active region.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end else if (gnt == GNT_FETCH) begin
            pixel       <= mem_rdata;
            pixel_valid <= 1'b1;
        end else if (clk_div && !disp_active) begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end
    end

    // Stall tracker: count waiting cycles, fold into the saturating maximum on each ack.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            stall_cnt <= '0;
            stall_max <= '0;
        end else if (wr_ack) begin
            stall_max <= max_u8(stall_max, stall_cnt);
            stall_cnt <= '0;
        end else if (wr_req && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// tb/tb_fb_scan_arbiter.sv - scoreboard bench for fb_scan_arbiter
`timescale 1ns/1ps
module tb_fb_scan_arbiter;
    import fb_pkg::*;

    typedef struct {
        int          due;
        logic [16:0] addr;
    } rd_t;

    typedef struct {
        int          due;
        logic [11:0] val;
    } pix_t;

    typedef struct {
        logic [16:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        clk_div;
    logic        disp_active;
    logic [11:0] xpose;
    logic [11:0] ypose;
    logic        wr_blank_only;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] pixel;
    logic        pixel_valid;
    logic [7:0]  wr_stall_max;

    int   cyc = 0;
    int   chk_cnt = 0;
    int   err_cnt = 0;
    rd_t  rd_q[$];
    pix_t pix_q[$];
    wr_t  wr_q[$];

    fb_scan_arbiter u_dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .clk_div       (clk_div),
        .disp_active   (disp_active),
        .xpose         (xpose),
        .ypose         (ypose),
        .wr_blank_only (wr_blank_only),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .pixel         (pixel),
        .pixel_valid   (pixel_valid),
        .wr_stall_max  (wr_stall_max)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [11:0] rd_fn(input logic [16:0] a);
        return a[11:0] ^ 12'hA5C;
    endfunction

    function automatic logic [16:0] exp_addr(input int x, input int y);
        int a;
        a = (y / 2) * FB_W_DEF + (x / 2);
        return a[16:0];
    endfunction

    // RAM model: read data presented while the read command is on the bus.
    assign mem_rdata = (mem_en && !mem_we) ? rd_fn(mem_addr) : 12'h000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic next_quiet();
        step();
        clk_div = 1'b0;
    endtask

    task automatic fetch_tick(input int x, input int y, input bit want_pix);
        logic [16:0] a;
        a           = exp_addr(x, y);
        clk_div     = 1'b1;
        disp_active = 1'b1;
        xpose       = x[11:0];
        ypose       = y[11:0];
        rd_q.push_back('{cyc + 1, a});
        if (want_pix) pix_q.push_back('{cyc + 2, rd_fn(a)});
    endtask

    // Scoreboard side: pop expectations as the DUT drives the RAM and the pixel register.
    always @(negedge clk_in) begin : mon
        rd_t  re;
        pix_t pe;
        wr_t  we;
        if (mem_en && !mem_we) begin
            chk("rd_pending", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) begin
                re = rd_q.pop_front();
                chk("rd_addr", mem_addr, re.addr);
                chk("rd_cycle", cyc, re.due);
            end
        end
        if (mem_en && mem_we) begin
            chk("wr_pending", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) begin
                we = wr_q.pop_front();
                chk("wr_addr", mem_addr, we.addr);
                chk("wr_data", mem_wdata, we.data);
            end
        end
        if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
            pe = pix_q.pop_front();
            chk("pix_value", pixel, pe.val);
            chk("pix_valid", pixel_valid, 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_ack;
        int last_ack;
        rst = 1'b1; clk_div = 1'b0; disp_active = 1'b0; xpose = '0; ypose = '0;
        wr_blank_only = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        @(negedge clk_in);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_pixel", pixel, 0);
        chk("rst_pixel_valid", pixel_valid, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_stall_max", wr_stall_max, 0);
        step();
        rst = 1'b0;

        // Fetch at x=3, y=5 with 1-in-4 ticks, then a short run along the line.
        fetch_tick(3, 5, 1);
        next_quiet();
        @(negedge clk_in);
        chk("fetch_addr_641", mem_addr, 641);
        step();
        @(negedge clk_in);
        chk("fetch_pix_lat2", pixel, rd_fn(17'd641));
        step(); step();
        for (int i = 0; i < 4; i++) begin
            fetch_tick(4 + 2 * i, 5 + i, 1);
            next_quiet(); step(); step();
        end

        // Conflict: write request lands in a fetch slot.
        wr_req = 1'b1; wr_addr = 17'h01234; wr_data = 12'hABC;
        wr_q.push_back('{17'h01234, 12'hABC});
        fetch_tick(10, 20, 1);
        @(negedge clk_in);
        chk("conf_no_ack_in_fetch", wr_ack, 0);
        next_quiet();
        @(negedge clk_in);
        chk("conf_ack", wr_ack, 1);
        step();
        wr_req = 1'b0;
        @(negedge clk_in);
        chk("conf_we", mem_we, 1);
        chk("conf_stall_max", wr_stall_max, 1);
        step(); step();

        // Blank-only: request held through the active region.
        wr_blank_only = 1'b1; wr_req = 1'b1; wr_addr = 17'h00222; wr_data = 12'h5A5;
        wr_q.push_back('{17'h00222, 12'h5A5});
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) fetch_tick(100 + i, 10, 1);
            else clk_div = 1'b0;
            @(negedge clk_in);
            chk("blank_no_ack", wr_ack, 0);
            step();
        end
        disp_active = 1'b0; clk_div = 1'b0;
        @(negedge clk_in);
        chk("blank_first_ack", wr_ack, 1);
        step();
        wr_req = 1'b0;
        @(negedge clk_in);
        chk("blank_stall_max", wr_stall_max, 8);
        chk("blank_pix_held", pixel_valid, 1);
        step();
        clk_div = 1'b1;
        next_quiet();
        @(negedge clk_in);
        chk("blank_pix_clr", pixel, 0);
        chk("blank_valid_clr", pixel_valid, 0);
        step();

        // Boundary: last visible position, then blanking tick.
        wr_blank_only = 1'b0;
        fetch_tick(639, 479, 1);
        next_quiet();
        @(negedge clk_in);
        chk("bound_addr_76799", mem_addr, 76799);
        step();
        disp_active = 1'b0;
        @(negedge clk_in);
        chk("bound_pix_valid", pixel_valid, 1);
        step();
        clk_div = 1'b1;
        next_quiet();
        @(negedge clk_in);
        chk("bound_pix_clr", pixel, 0);
        chk("bound_valid_clr", pixel_valid, 0);
        step();

        // Reset in the cycle after a fetch issue.
        fetch_tick(40, 30, 1);
        next_quiet(); step();
        @(negedge clk_in);
        chk("pre_rst_valid", pixel_valid, 1);
        step(); step();
        fetch_tick(0, 0, 0);
        next_quiet();
        rst = 1'b1; disp_active = 1'b0; wr_req = 1'b1;
        wr_addr = 17'h1F0F0; wr_data = 12'h321;
        @(negedge clk_in);
        chk("rst_mid_ack", wr_ack, 0);
        step();
        @(negedge clk_in);
        chk("rst_mid_pixel", pixel, 0);
        chk("rst_mid_valid", pixel_valid, 0);
        chk("rst_mid_mem_en", mem_en, 0);
        chk("rst_mid_ack2", wr_ack, 0);
        chk("rst_mid_stall_max", wr_stall_max, 0);
        step();
        rst = 1'b0;
        wr_q.push_back('{17'h1F0F0, 12'h321});
        @(negedge clk_in);
        chk("post_rst_ack", wr_ack, 1);
        step();
        wr_req = 1'b0;
        step(); step();

        // Back-to-back writes during blanking with the request held.
        disp_active = 1'b0; wr_blank_only = 1'b1;
        n_ack = 0; last_ack = 0;
        wr_req = 1'b1; wr_addr = 17'h10000; wr_data = 12'h100;
        for (int c = 0; c < 30 && n_ack < 6; c++) begin
            bit acked;
            acked = 1'b0;
            clk_div = (c % 4 == 0);
            @(negedge clk_in);
            if (wr_ack) begin
                wr_q.push_back('{wr_addr, wr_data});
                if (n_ack > 0) chk("b2b_gap", cyc - last_ack, 2);
                last_ack = cyc;
                n_ack++;
                acked = 1'b1;
            end
            step();
            if (acked) begin
                wr_addr = wr_addr + 17'd3;
                wr_data = wr_data + 12'h011;
                if (n_ack == 6) wr_req = 1'b0;
            end
        end
        clk_div = 1'b0;
        chk("b2b_acks", n_ack, 6);
        repeat (3) step();
        @(negedge clk_in);
        chk("b2b_stall_max", wr_stall_max, 1);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("pix_q_drained", pix_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
